sipo_deserializer: RTL

- Serial-in, parallel-out receiver for the team's MSB-first serial word stream.
- Shifts one bit per qualified strobe and counts bits to a WIDTH-bit word boundary.
- Presents each completed word on a valid/ready parallel output with a one-word holding register.
- Sits at the receive end of a serial link, feeding parallel consumers such as FIFOs and register files.

---
 rtl/sipo_pkg.sv | 28 ++
 rtl/sipo_bit_counter.sv | 59 +++++
 rtl/sipo_deserializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and constants for the SIPO deserializer.
//               Holds the receive FSM state encoding, the output
//               holding-register state encoding and the default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Default parallel word width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Receive FSM: IDLE when no bits of the current word have been taken,
  // SHIFT while a partial word is being assembled.
  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  // One-word output holding register occupancy.
  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : sipo_bit_counter
// Description : Counts accepted serial bits within one word. Increments on
//               each accepted bit, wraps from WIDTH-1 to 0 on the word's
//               final bit, and reloads to 1 when a frame marker arrives
//               (the marked bit is the first bit of a fresh word).
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               inc   - a bit is accepted this cycle
//               sync  - frame marker, honoured only together with inc
//               count - bits accepted so far in the current word
//               last  - count == WIDTH-1 (next accepted bit ends the word)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             sync,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign last  = (count_q == CNT_W'(WIDTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      // A frame marker wins over the wrap: the marked bit starts a word.
      if (sync) begin
        count_d = CNT_W'(1);
      end else if (last) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : sipo_bit_counter
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in / parallel-out receiver for an MSB-first serial
//               word stream. Bits are shifted in on sin_valid, words are
//               delimited by a bit counter (optionally realigned by
//               sin_sync), and each completed word is offered on a
//               valid/ready port backed by a one-word holding register.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset
//               sin        - serial data bit
//               sin_valid  - qualifies sin
//               sin_sync   - with sin_valid: current bit is a word's MSB
//               dout       - completed word, MSB = first bit received
//               dout_valid - dout holds an unconsumed word
//               dout_ready - consumer accepts dout when dout_valid is high
//               overrun    - 1-cycle pulse: completed word dropped (full)
//               frame_err  - 1-cycle pulse: sin_sync hit a partial word
//               bit_count  - bits accepted in the current partial word
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_count
);

  // Only the WIDTH-1 previously received bits need storing; the final bit
  // of a word is taken straight from sin when the word completes.
  logic [WIDTH-2:0] shreg_q,      shreg_d;
  rx_state_e        rx_state_q,   rx_state_d;
  hold_state_e      hold_state_q, hold_state_d;
  logic [WIDTH-1:0] dout_q,       dout_d;
  logic             overrun_q,    overrun_d;
  logic             frame_err_q,  frame_err_d;

  logic             cnt_last;
  logic [WIDTH-1:0] word;
  logic             complete;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (sin_valid),
    .sync  (sin_sync),
    .count (bit_count),
    .last  (cnt_last)
  );

  assign word     = {shreg_q, sin};
  // A marked bit always starts a new word, so it can never complete one.
  assign complete = sin_valid && !sin_sync && cnt_last;

  always_comb begin
    shreg_d      = shreg_q;
    rx_state_d   = rx_state_q;
    hold_state_d = hold_state_q;
    dout_d       = dout_q;
    overrun_d    = 1'b0;
    frame_err_d  = 1'b0;

    if (sin_valid) begin
      if (sin_sync) begin
        // Discard the partial word; this bit becomes the new MSB.
        shreg_d     = (WIDTH-1)'(sin);
        rx_state_d  = RX_SHIFT;
        frame_err_d = (rx_state_q == RX_SHIFT);
      end else begin
        shreg_d    = word[WIDTH-2:0];
        rx_state_d = cnt_last ? RX_IDLE : RX_SHIFT;
      end
    end

    if (complete) begin
      // A same-cycle handshake frees the slot for the incoming word.
      if ((hold_state_q == HOLD_EMPTY) || dout_ready) begin
        dout_d       = word;
        hold_state_d = HOLD_FULL;
      end else begin
        overrun_d = 1'b1;
      end
    end else if ((hold_state_q == HOLD_FULL) && dout_ready) begin
      hold_state_d = HOLD_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q      <= '0;
      rx_state_q   <= RX_IDLE;
      hold_state_q <= HOLD_EMPTY;
      dout_q       <= '0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      rx_state_q   <= rx_state_d;
      hold_state_q <= hold_state_d;
      dout_q       <= dout_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (hold_state_q == HOLD_FULL);
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule : sipo_deserializer
`default_nettype wire
